// File: rtl/buffered_serial_tx.sv
// Buffered serial transmitter: a DEPTH-word FIFO feeding a UART-style framer
// (start bit, LSB-first data, optional parity, one or two stop bits).
module buffered_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data,
  input  logic                   we,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, empty_q, overflow_q;
  logic              push, pop;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q, shift_nxt;
  logic              parity_q;
  logic [TW-1:0]     tmr_q;
  logic [IW-1:0]     idx_q;
  logic              tx_q, busy_q;
  logic              bit_end;

  // full is taken from the registered count, so a pop on the same edge never frees a slot for a write
  assign push      = we && !full_q;
  assign pop       = (state_q == IDLE) && !empty_q;
  assign bit_end   = (tmr_q == TMR_LAST);
  assign shift_nxt = shift_q >> 1;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= we && full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  // The frame works from its own copy of the word, so FIFO traffic cannot disturb it
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q  <= mem_q[rd_ptr_q];
      parity_q <= (^mem_q[rd_ptr_q]) ^ PARITY_ODD;
    end else if ((state_q == DATA) && bit_end) begin
      shift_q  <= shift_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            tmr_q   <= '0;
            idx_q   <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tmr_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            tmr_q <= '0;
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY_EN) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IW'(1);
              tx_q  <= shift_nxt[0];
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tmr_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            tmr_q <= '0;
            if (idx_q == STOP_LAST) begin
              idx_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_buffered_serial_tx.sv
// Bench for buffered_serial_tx: a queue-based frame model for the default build
// checked every cycle, plus hand-computed vectors on parity and narrow builds.
module tb_buffered_serial_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] a_data;  logic a_we;  logic a_full, a_empty, a_tx, a_busy, a_ovf;  logic [3:0] a_count;
  logic [7:0] b_data;  logic b_we;  logic b_full, b_empty, b_tx, b_busy, b_ovf;  logic [3:0] b_count;
  logic [4:0] c_data;  logic c_we;  logic c_full, c_empty, c_tx, c_busy, c_ovf;  logic [2:0] c_count;

  buffered_serial_tx dut_a (
    .clk(clk), .rst(rst), .data(a_data), .we(a_we), .full(a_full), .empty(a_empty),
    .count(a_count), .tx(a_tx), .busy(a_busy), .overflow(a_ovf)
  );

  buffered_serial_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .data(b_data), .we(b_we), .full(b_full), .empty(b_empty),
    .count(b_count), .tx(b_tx), .busy(b_busy), .overflow(b_ovf)
  );

  buffered_serial_tx #(.DATA_W(5), .DEPTH(4), .CLKS_PER_BIT(1)) dut_c (
    .clk(clk), .rst(rst), .data(c_data), .we(c_we), .full(c_full), .empty(c_empty),
    .count(c_count), .tx(c_tx), .busy(c_busy), .overflow(c_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of dut_a: FIFO as a queue, the frame as a queue of per-cycle line levels
  localparam int M_W = 8, M_DEPTH = 8, M_CPB = 4;
  logic [7:0] m_fifo [$];
  bit         m_txq  [$];
  bit         m_ovf = 1'b0;
  bit         m_live = 1'b0;
  bit         m_was_idle, m_was_full;
  logic [7:0] m_word;

  always @(posedge clk) begin
    m_was_idle = (m_txq.size() == 0);
    m_was_full = (m_fifo.size() == M_DEPTH);
    if (rst) begin
      m_fifo.delete();
      m_txq.delete();
      m_ovf = 1'b0;
    end else begin
      if (!m_was_idle) m_txq.delete(0);
      if (m_was_idle && m_fifo.size() > 0) begin
        m_word = m_fifo.pop_front();
        for (int c = 0; c < M_CPB; c++) m_txq.push_back(1'b0);
        for (int b = 0; b < M_W; b++)
          for (int c = 0; c < M_CPB; c++) m_txq.push_back(m_word[b]);
        for (int c = 0; c < M_CPB; c++) m_txq.push_back(1'b1);
      end
      m_ovf = a_we && m_was_full;
      if (a_we && !m_was_full) m_fifo.push_back(a_data);
    end
    m_live = 1'b1;
  end

  logic [8:0] m_exp, m_act;
  int a_ovf_seen = 0;

  always @(negedge clk) begin
    if (m_live) begin
      m_exp = {(m_txq.size() > 0) ? m_txq[0] : 1'b1, m_txq.size() > 0,
               m_fifo.size() == M_DEPTH, m_fifo.size() == 0, m_ovf, 4'(m_fifo.size())};
      m_act = {a_tx, a_busy, a_full, a_empty, a_ovf, a_count};
      check("model_a{tx,busy,full,empty,ovf,count}", 32'(m_act), 32'(m_exp));
      if (a_ovf === 1'b1) a_ovf_seen++;
    end
  end

  // Bit-period line levels: start, LSB-first data, [parity], stop
  bit pat_a [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  bit pat_b [12] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  bit pat_c [7]  = '{0, 1, 0, 1, 0, 1, 1};

  int peak, busy_cyc, rises, ovf_base;
  logic prev_busy;

  initial begin
    rst = 1'b1;
    a_we = 1'b0; b_we = 1'b0; c_we = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (2) @(negedge clk);
    check("rst_tx", a_tx, 1);
    check("rst_full", a_full, 0);
    check("rst_empty", a_empty, 1);
    check("rst_count", a_count, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ovf", a_ovf, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame on all three builds: 0x03, 0x03 with odd parity, 0x15 narrow
    a_we = 1'b1; a_data = 8'h03; b_we = 1'b1; b_data = 8'h03; c_we = 1'b1; c_data = 5'h15;
    @(negedge clk);
    a_we = 1'b0; b_we = 1'b0; c_we = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i < 40) begin
        check("a_frame_tx", a_tx, pat_a[i/4]);
        check("a_frame_busy", a_busy, 1);
      end else if (i == 40) begin
        check("a_after_busy", a_busy, 0);
        check("a_after_tx", a_tx, 1);
      end
      if (i < 48) begin
        check("b_frame_tx", b_tx, pat_b[i/4]);
        check("b_frame_busy", b_busy, 1);
      end else if (i == 48) begin
        check("b_after_busy", b_busy, 0);
      end
      if (i < 7) begin
        check("c_frame_tx", c_tx, pat_c[i]);
        check("c_frame_busy", c_busy, 1);
      end else if (i == 7) begin
        check("c_after_busy", c_busy, 0);
        check("c_after_tx", c_tx, 1);
      end
    end

    // Writes on alternate cycles: three back-to-back frames
    peak = 0; busy_cyc = 0; rises = 0; prev_busy = a_busy;
    for (int i = 0; i < 140; i++) begin
      if (i < 6) begin
        a_we = (i % 2 == 0);
        a_data = 8'(3 + i / 2);
      end else begin
        a_we = 1'b0;
      end
      @(negedge clk);
      if (int'(a_count) > peak) peak = int'(a_count);
      if (a_busy) busy_cyc++;
      if (a_busy && !prev_busy) rises++;
      prev_busy = a_busy;
    end
    check("alt_peak_count", 32'(peak), 2);
    check("alt_busy_cycles", 32'(busy_cyc), 120);
    check("alt_frames", 32'(rises), 3);

    // Ten consecutive writes while idle: the tenth is dropped
    ovf_base = a_ovf_seen;
    for (int i = 1; i <= 10; i++) begin
      a_we = 1'b1; a_data = 8'(i);
      @(negedge clk);
    end
    a_we = 1'b0;
    check("burst_count", a_count, 8);
    check("burst_full", a_full, 1);
    check("burst_ovf", a_ovf, 1);
    @(negedge clk);
    check("burst_ovf_clear", a_ovf, 0);
    repeat (380) @(negedge clk);
    check("burst_ovf_pulses", 32'(a_ovf_seen - ovf_base), 1);
    check("burst_drained", a_empty, 1);

    // Reset in the middle of a data bit with three words queued
    for (int i = 0; i < 4; i++) begin
      a_we = 1'b1; a_data = 8'(8'h11 * (i + 1));
      @(negedge clk);
    end
    a_we = 1'b0;
    check("pre_rst_count", a_count, 3);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", a_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx", a_tx, 1);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_empty", a_empty, 1);
    check("mid_rst_busy", a_busy, 0);
    busy_cyc = 0;
    repeat (60) begin
      @(negedge clk);
      if (a_busy) busy_cyc++;
    end
    check("post_rst_quiet", 32'(busy_cyc), 0);

    // Narrow build fills at four words
    for (int i = 1; i <= 6; i++) begin
      c_we = 1'b1; c_data = 5'(i);
      @(negedge clk);
      if (i == 5) begin
        check("c_full_count", c_count, 4);
        check("c_full", c_full, 1);
      end
    end
    c_we = 1'b0;
    check("c_ovf", c_ovf, 1);
    check("c_ovf_count", c_count, 4);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffered_serial_tx.md
BUFFERED_SERIAL_TX -- requirements
Module: buffered_serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each data word.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO depth in words; power of two, at least 2.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; at least 1.
REQ-004 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-006 SHALL have parameter STOP_BITS, default 1: number of stop bits, 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port data, input, DATA_W bits: word to enqueue.
REQ-010 SHALL have port we, input, 1 bit: write-enable, sampled each rising edge.
REQ-011 SHALL have port full, output, 1 bit: high when the FIFO holds DEPTH words.
REQ-012 SHALL have port empty, output, 1 bit: high when the FIFO holds 0 words.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: number of words currently in the FIFO.
REQ-014 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL accept a write on an edge where we=1 and full=0: store data at the write pointer, then advance the pointer modulo DEPTH.
REQ-018 SHALL drop a write on an edge where we=1 and full=1, leave FIFO contents unchanged, and assert overflow for exactly the next cycle.
REQ-019 SHALL derive full from the registered count, so a write on an edge where a pop also occurs while full is still dropped.
REQ-020 SHALL, on a simultaneous accepted push and pop, leave count unchanged and move both pointers.
REQ-021 SHALL drive count, full and empty from registers, updated on the same edge as the push/pop.
REQ-022 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-023 SHALL, in IDLE with empty=0, pop the head word into a shift register and move to START on that edge.
REQ-024 SHALL, in IDLE with empty=1, hold IDLE with tx=1.
REQ-025 SHALL hold START with tx=0 for CLKS_PER_BIT cycles.
REQ-026 SHALL hold DATA for DATA_W bit periods of CLKS_PER_BIT cycles each, sending data LSB first.
REQ-027 SHALL enter PARITY after DATA only when PARITY_EN=1: one bit period, bit = XOR of the word, inverted when PARITY_ODD=1.
REQ-028 SHALL hold STOP with tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-029 SHALL spend exactly one cycle in IDLE (the pop cycle) between back-to-back frames.
REQ-030 SHALL give first-write latency of 2 edges: we on edge N, pop on edge N+1, tx=0 after edge N+1.
REQ-031 SHALL time bit periods with a clog2(CLKS_PER_BIT)-wide bit-timer and a bit index counter; neither may wrap beyond its terminal value.
REQ-032 SHALL keep a frame's data word stable during transmission regardless of FIFO activity.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, clear the pointers, count, bit timer and bit index, enter IDLE, and give tx=1, full=0, empty=1, count=0, busy=0, overflow=0 from that edge on.
REQ-034 SHALL let reset override we and any frame in progress; an aborted frame is not resumed and queued words are discarded.

Verification
REQ-035 SHALL be checked with defaults: write 0x03 once; tx from edge N+1 = 0 for 4 cycles, then 1,1,0,0,0,0,0,0 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles.
REQ-036 SHALL be checked with writes of 0x03, 0x04, 0x05 on alternate cycles: three frames go out in order with one idle-high cycle between them; count peaks at 2.
REQ-037 SHALL be checked with 10 consecutive writes while IDLE: 9 accepted (one popped), count=8, full=1, overflow pulses once for the 10th write; later output contains words 1-9 only.
REQ-038 SHALL be checked with PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, data 0x03: parity bit=1, tx high for 8 cycles after parity, frame length 48 cycles.
REQ-039 SHALL be checked with rst=1 mid-DATA of a frame while 3 words are queued: next cycle tx=1, count=0, empty=1, busy=0; no further frames without new writes.
REQ-040 SHALL be checked with DATA_W=5, DEPTH=4, CLKS_PER_BIT=1, data 0x15: tx bits 0,1,0,1,0,1,1 on consecutive cycles; full at 4 queued words.
